// File: rtl/jtag_report_scheduler.sv
// ============================================================================
// Module      : jtag_report_scheduler
// Description : Round-robin sequencer for the shared debug-bridge JTAG channel.
//               Streams report bursts to the host; decodes host commands between bursts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_report_scheduler #(
    parameter int          NREQ       = 4,
    parameter int          LENW       = 4,
    parameter logic [7:0]  REPORT_CMD = 8'hFE
) (
    input  logic                   clk,
    input  logic                   reset_in,
    output logic [31:0]            bridge_d,
    input  logic [31:0]            bridge_q,
    output logic                   bridge_req,
    output logic                   bridge_wr,
    input  logic                   bridge_ack,
    input  logic [NREQ-1:0]        src_req,
    input  logic [NREQ*LENW-1:0]   src_len,
    input  logic [NREQ*32-1:0]     src_data,
    output logic [LENW-1:0]        src_idx,
    output logic [NREQ-1:0]        src_grant,
    output logic [NREQ-1:0]        src_done,
    output logic                   cmd_valid,
    output logic [31:0]            cmd_q,
    output logic [NREQ-1:0]        cmd_report,
    output logic                   busy
);

    localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GAP_R = 3'd1,
        S_ARB   = 3'd2,
        S_LOAD  = 3'd3,
        S_SEND  = 3'd4,
        S_GAP_W = 3'd5
    } state_t;

    state_t             r_state;
    logic [c_IW-1:0]    r_ptr;
    logic [c_IW-1:0]    r_gidx;
    logic [LENW-1:0]    r_len;

    logic [c_IW-1:0]    w_pick;
    logic               w_found;
    logic [NREQ-1:0]    w_pick_oh;
    logic [c_IW-1:0]    w_ptr_next;
    logic [3:0]         w_cmd_sel;
    logic               w_cmd_hit;
    logic [NREQ-1:0]    w_cmd_oh;
    logic               w_last;

    // First requesting source at or after the pointer, scanning cyclically.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!w_found && src_req[j]) begin
                w_found = 1'b1;
                w_pick  = c_IW'(j);
            end
        end
    end

    assign w_cmd_sel  = bridge_q[3:0];
    assign w_cmd_hit  = (bridge_q[31:24] == REPORT_CMD) && ({28'd0, w_cmd_sel} < 32'(NREQ));
    assign w_ptr_next = (r_gidx == c_IW'(NREQ - 1)) ? '0 : r_gidx + c_IW'(1);
    assign w_last     = (src_idx == r_len);

    always_comb begin
        w_pick_oh = '0;
        w_cmd_oh  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_pick_oh[i] = (w_pick == c_IW'(i));
            w_cmd_oh[i]  = w_cmd_hit && (w_cmd_sel == 4'(i));
        end
    end

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_gidx     <= '0;
            r_len      <= '0;
            bridge_req <= 1'b0;
            bridge_wr  <= 1'b0;
            bridge_d   <= '0;
            src_idx    <= '0;
            src_grant  <= '0;
            src_done   <= '0;
            cmd_valid  <= 1'b0;
            cmd_q      <= '0;
            cmd_report <= '0;
        end else begin
            src_done   <= '0;
            cmd_valid  <= 1'b0;
            cmd_report <= '0;
            case (r_state)
                S_IDLE: begin
                    // A host word completing this cycle takes priority over a new report.
                    if (bridge_req && bridge_ack) begin
                        cmd_q      <= bridge_q;
                        cmd_valid  <= 1'b1;
                        cmd_report <= w_cmd_oh;
                        bridge_req <= 1'b0;
                        r_state    <= S_GAP_R;
                    end else if (|src_req) begin
                        bridge_req <= 1'b0;
                        r_state    <= S_ARB;
                    end else begin
                        bridge_req <= 1'b1;
                        bridge_wr  <= 1'b0;
                    end
                end
                S_GAP_R: begin
                    bridge_wr <= 1'b0;
                    if (|src_req) begin
                        r_state <= S_ARB;
                    end else begin
                        bridge_req <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                S_ARB: begin
                    if (w_found) begin
                        src_grant <= w_pick_oh;
                        r_gidx    <= w_pick;
                        r_len     <= src_len[int'(w_pick)*LENW +: LENW];
                        src_idx   <= '0;
                        r_state   <= S_LOAD;
                    end else begin
                        bridge_req <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    bridge_d   <= src_data[int'(r_gidx)*32 +: 32];
                    bridge_req <= 1'b1;
                    bridge_wr  <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (bridge_ack) begin
                        bridge_req <= 1'b0;
                        if (w_last) begin
                            src_done  <= src_grant;
                            src_grant <= '0;
                            r_ptr     <= w_ptr_next;
                            bridge_wr <= 1'b0;
                            r_state   <= S_GAP_R;
                        end else begin
                            src_idx <= src_idx + LENW'(1);
                            r_state <= S_GAP_W;
                        end
                    end
                end
                S_GAP_W: begin
                    r_state <= S_LOAD;
                end
                default: begin
                    bridge_req <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
